// File: rtl/psk_pkg.sv
// Shared definitions for the M-PSK differential encoder: mode constants,
// FSM state encoding and the k-bit phase mask helper.
package psk_pkg;

  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_BPSK = 3'd1;
  localparam logic [MODE_W-1:0] MODE_QPSK = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    REF,
    DATA
  } psk_state_e;

  function automatic logic [7:0] phase_mask(input logic [MODE_W-1:0] k);
    return 8'((9'd1 << k) - 9'd1);
  endfunction

endpackage

// File: rtl/psk_phase_acc.sv
// Modular k-bit phase accumulator: p_next = (p + d) & mask, register
// updated on accepted beats and returned to INIT on frame end.
module psk_phase_acc #(
  parameter int W = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] mask,
  input  logic [W-1:0] d,
  output logic [W-1:0] p_next
);

  logic [W-1:0] p;

  // p keeps the unmasked INIT value; masking the sum makes that equivalent
  assign p_next = (p + d) & mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= INIT;
    end else if (en) begin
      p <= clr ? INIT : p_next;
    end
  end

endmodule

// File: rtl/psk_diff_encoder.sv
// Differential M-PSK encoder as a full AXIS register stage; phase restarts
// every frame. Optional reference symbol per frame: PSK_DIFF_REF_SYM_EN.
module psk_diff_encoder
  import psk_pkg::*;
#(
  parameter int BYTES      = 1,
  parameter int MAX_BPS    = 2,
  parameter int INIT_PHASE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BYTES*8-1:0]   data_tdata,
  input  logic                 data_tvalid,
  output logic                 data_tready,
  input  logic                 data_tlast,
  input  logic [MODE_W-1:0]    data_tuser,
  output logic [BYTES*8-1:0]   encoded_tdata,
  output logic                 encoded_tvalid,
  input  logic                 encoded_tready,
  output logic                 encoded_tlast,
  output logic [MODE_W-1:0]    encoded_tuser
);

  localparam int DW = BYTES * 8;
  localparam logic [MAX_BPS-1:0] INIT_P = MAX_BPS'(INIT_PHASE);

  psk_state_e          state, state_nxt;
  logic [MODE_W-1:0]   k_reg, k_in, k_cur;
  logic [MAX_BPS-1:0]  mask, p_next;
  logic                out_free, hold, in_acc, ref_load;
  logic                unused_tdata;

  assign unused_tdata = ^data_tdata;

  always_comb begin
    k_in = data_tuser;
    if (data_tuser == '0) begin
      k_in = MODE_BPSK;
    end else if (data_tuser > MODE_W'(MAX_BPS)) begin
      k_in = MODE_W'(MAX_BPS);
    end
  end

  // Mode comes straight from tuser on a frame's first beat, latched afterwards
  assign k_cur    = (state == IDLE) ? k_in : k_reg;
  assign mask     = MAX_BPS'(phase_mask(k_cur));
  assign out_free = !encoded_tvalid || encoded_tready;

`ifdef PSK_DIFF_REF_SYM_EN
  assign hold = (state == IDLE) && data_tvalid;
`else
  assign hold = 1'b0;
`endif

  assign data_tready = rst_n && !hold && out_free;
  assign in_acc      = data_tvalid && data_tready;
  assign ref_load    = hold && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ref_load) begin
          state_nxt = REF;
        end else if (in_acc && !data_tlast) begin
          state_nxt = DATA;
        end
      end
      // The first data beat can be taken in the same cycle the reference leaves
      REF: begin
        if (in_acc) begin
          state_nxt = data_tlast ? IDLE : DATA;
        end else if (encoded_tready) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (in_acc && data_tlast) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg <= '0;
    end else if ((state == IDLE) && (in_acc || ref_load)) begin
      k_reg <= k_in;
    end
  end

  psk_phase_acc #(
    .W    (MAX_BPS),
    .INIT (INIT_P)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_acc),
    .clr    (data_tlast),
    .mask   (mask),
    .d      (data_tdata[MAX_BPS-1:0]),
    .p_next (p_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      encoded_tdata  <= '0;
      encoded_tvalid <= 1'b0;
      encoded_tlast  <= 1'b0;
      encoded_tuser  <= '0;
    end else if (in_acc) begin
      encoded_tdata  <= DW'(p_next);
      encoded_tvalid <= 1'b1;
      encoded_tlast  <= data_tlast;
      encoded_tuser  <= k_cur;
    end else if (ref_load) begin
      encoded_tdata  <= DW'(INIT_P & mask);
      encoded_tvalid <= 1'b1;
      encoded_tlast  <= 1'b0;
      encoded_tuser  <= k_in;
    end else if (encoded_tready) begin
      encoded_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psk_diff_encoder.sv
// Directed bench for psk_diff_encoder (BYTES=1, MAX_BPS=2, INIT_PHASE=0);
// adds reference-symbol steps when PSK_DIFF_REF_SYM_EN is defined.
module tb_psk_diff_encoder;
  import psk_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tready;
  logic       data_tlast;
  logic [2:0] data_tuser;
  logic [7:0] encoded_tdata;
  logic       encoded_tvalid;
  logic       encoded_tready;
  logic       encoded_tlast;
  logic [2:0] encoded_tuser;

  int checks = 0;
  int errors = 0;

  logic [7:0] bp_d [8] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd3, 8'd3, 8'd1, 8'd2};
  logic [7:0] exp_p [$];
  logic       exp_l [$];
  int         got, cyc, n_exp;
  bit         held;
  logic [7:0] hd;
  logic       hl;
  logic [2:0] hu;

  always #5 clk = ~clk;

  psk_diff_encoder #(
    .BYTES      (1),
    .MAX_BPS    (2),
    .INIT_PHASE (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_tdata     (data_tdata),
    .data_tvalid    (data_tvalid),
    .data_tready    (data_tready),
    .data_tlast     (data_tlast),
    .data_tuser     (data_tuser),
    .encoded_tdata  (encoded_tdata),
    .encoded_tvalid (encoded_tvalid),
    .encoded_tready (encoded_tready),
    .encoded_tlast  (encoded_tlast),
    .encoded_tuser  (encoded_tuser)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and return #1 after the edge that accepted it
  task automatic push(input logic [7:0] d, input logic [2:0] k, input logic last);
    int n;
    n = 0;
    data_tdata  = d;
    data_tuser  = k;
    data_tlast  = last;
    data_tvalid = 1'b1;
    @(negedge clk); #2;
    while (!data_tready && n < 50) begin
      @(negedge clk); #2;
      n++;
    end
    chk("push_ready", 32'(data_tready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] p, input logic last,
                            input logic [2:0] k);
    chk({tag, ".valid"}, 32'(encoded_tvalid), 32'd1);
    chk({tag, ".data"},  32'(encoded_tdata),  32'(p));
    chk({tag, ".last"},  32'(encoded_tlast),  32'(last));
    chk({tag, ".mode"},  32'(encoded_tuser),  32'(k));
  endtask

  task automatic idle(input int cycles);
    data_tvalid = 1'b0;
    data_tlast  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    data_tdata     = '0;
    data_tvalid    = 1'b0;
    data_tlast     = 1'b0;
    data_tuser     = '0;
    encoded_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(encoded_tvalid), 32'd0);
    chk("rst.data",  32'(encoded_tdata),  32'd0);
    chk("rst.last",  32'(encoded_tlast),  32'd0);
    chk("rst.mode",  32'(encoded_tuser),  32'd0);
    chk("rst.ready", 32'(data_tready),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.ready", 32'(data_tready), 32'd1);

    // BPSK frame, junk in upper tdata bits: d = 1,1,0,1 -> p = 1,0,0,1
    push(8'hF1, MODE_BPSK, 1'b0); expect_out("bpsk0", 8'd1, 1'b0, 3'd1);
    push(8'h03, MODE_BPSK, 1'b0); expect_out("bpsk1", 8'd0, 1'b0, 3'd1);
    push(8'hFE, MODE_BPSK, 1'b0); expect_out("bpsk2", 8'd0, 1'b0, 3'd1);
    push(8'h81, MODE_BPSK, 1'b1); expect_out("bpsk3", 8'd1, 1'b1, 3'd1);
    idle(2);
    chk("bpsk.drain", 32'(encoded_tvalid), 32'd0);

    // QPSK d = 3,2,1,0 -> 3,1,2,2, then back-to-back frame d = 1 -> 1
    push(8'hFB, MODE_QPSK, 1'b0); expect_out("qpsk0", 8'd3, 1'b0, 3'd2);
    push(8'h06, MODE_QPSK, 1'b0); expect_out("qpsk1", 8'd1, 1'b0, 3'd2);
    push(8'h05, MODE_QPSK, 1'b0); expect_out("qpsk2", 8'd2, 1'b0, 3'd2);
    push(8'hFC, MODE_QPSK, 1'b1); expect_out("qpsk3", 8'd2, 1'b1, 3'd2);
    push(8'h01, MODE_QPSK, 1'b1); expect_out("qpsk_b2b", 8'd1, 1'b1, 3'd2);
    idle(2);

    // Backpressure: ready toggles 1,0,1,0... over an 8-beat QPSK frame
`ifdef PSK_DIFF_REF_SYM_EN
    exp_p.push_back(8'd0); exp_l.push_back(1'b0);
`endif
    foreach (bp_d[i]) begin
      exp_l.push_back(i == 7);
    end
    exp_p.push_back(8'd1); exp_p.push_back(8'd3); exp_p.push_back(8'd2); exp_p.push_back(8'd2);
    exp_p.push_back(8'd1); exp_p.push_back(8'd0); exp_p.push_back(8'd1); exp_p.push_back(8'd3);
    n_exp = exp_p.size();
    got = 0;
    cyc = 0;
    held = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) push(bp_d[i], MODE_QPSK, 1'(i == 7));
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
      end
      begin
        while (got < n_exp && cyc < 200) begin
          @(negedge clk);
          encoded_tready = (cyc % 2 == 0);
          #1;
          if (held) begin
            chk("bp_hold.valid", 32'(encoded_tvalid), 32'd1);
            chk("bp_hold.data",  32'(encoded_tdata),  32'(hd));
            chk("bp_hold.last",  32'(encoded_tlast),  32'(hl));
            chk("bp_hold.mode",  32'(encoded_tuser),  32'(hu));
          end
          held = 1'b0;
          if (encoded_tvalid && encoded_tready) begin
            chk("bp.data", 32'(encoded_tdata), 32'(exp_p[got]));
            chk("bp.last", 32'(encoded_tlast), 32'(exp_l[got]));
            got++;
          end else if (encoded_tvalid) begin
            held = 1'b1;
            hd   = encoded_tdata;
            hl   = encoded_tlast;
            hu   = encoded_tuser;
          end
          cyc++;
        end
        chk("bp.count", 32'(got), 32'(n_exp));
      end
    join
    encoded_tready = 1'b1;
    @(negedge clk); #1;
    chk("bp.no_dup", 32'(encoded_tvalid), 32'd0);
    idle(1);

    // Mode clamp: tuser 7 -> QPSK; tuser 0 -> BPSK
    push(8'h03, 3'd7, 1'b0); expect_out("clamp0", 8'd3, 1'b0, 3'd2);
    push(8'h03, 3'd7, 1'b1); expect_out("clamp1", 8'd2, 1'b1, 3'd2);
    push(8'h01, 3'd0, 1'b0); expect_out("zero0",  8'd1, 1'b0, 3'd1);
    push(8'h01, 3'd0, 1'b1); expect_out("zero1",  8'd0, 1'b1, 3'd1);
    // tuser change mid-frame is ignored: stays BPSK, (1 + 3) & 1 = 0
    push(8'h01, MODE_BPSK, 1'b0); expect_out("latch0", 8'd1, 1'b0, 3'd1);
    push(8'h03, MODE_QPSK, 1'b1); expect_out("latch1", 8'd0, 1'b1, 3'd1);
    idle(2);

    // Reset mid-frame, then a fresh BPSK frame must start from phase 0
    push(8'h03, MODE_QPSK, 1'b0); expect_out("mid0", 8'd3, 1'b0, 3'd2);
    rst_n       = 1'b0;
    data_tvalid = 1'b0;
    #1;
    chk("midrst.valid", 32'(encoded_tvalid), 32'd0);
    chk("midrst.data",  32'(encoded_tdata),  32'd0);
    chk("midrst.last",  32'(encoded_tlast),  32'd0);
    chk("midrst.mode",  32'(encoded_tuser),  32'd0);
    chk("midrst.ready", 32'(data_tready),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(8'h03, MODE_BPSK, 1'b1); expect_out("postrst", 8'd1, 1'b1, 3'd1);
    idle(2);

`ifdef PSK_DIFF_REF_SYM_EN
    // Reference symbol: QPSK d = 1,1 -> 0 (ref), 1, 2
    data_tdata  = 8'h01;
    data_tuser  = MODE_QPSK;
    data_tlast  = 1'b0;
    data_tvalid = 1'b1;
    @(negedge clk); #2;
    chk("ref.hold_ready", 32'(data_tready), 32'd0);
    @(posedge clk); #1;
    expect_out("ref_sym", 8'd0, 1'b0, 3'd2);
    @(negedge clk); #2;
    chk("ref.data_ready", 32'(data_tready), 32'd1);
    @(posedge clk); #1;
    expect_out("ref_d0", 8'd1, 1'b0, 3'd2);
    push(8'h01, MODE_QPSK, 1'b1); expect_out("ref_d1", 8'd2, 1'b1, 3'd2);
    idle(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
